truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//   Characterises a combinational N_IN-input logic circuit (e.g. a 3-input gate netlist) by reading its truth table back out.
//   Steps through every input combination, waits for outputs to settle, samples, assembles the hex truth-table code.
//   Compares the result against an expected code.
//   Sits in the test harness opposite the truth-table-defined gate modules: they map code -> function, this maps function -> code.
// PARAMETERS
//   N_IN           3   number of DUT inputs, legal 1..4; code width CODE_W = 2**N_IN
//   SETTLE_CYCLES  4   cycles each input vector is held before sampling, legal >= 1
//   STABLE_CYCLES  2   final cycles of each hold window checked for stability, legal 1..SETTLE_CYCLES (used only with macro)
// PORTS
//   clk       in   1       single clock, all logic on rising edge
//   rst       in   1       synchronous reset, active-high
//   start     in   1       one-cycle request to begin a sweep; accepted only when busy==0
//   exp_code  in   CODE_W  expected truth-table code, sampled on the start-accept edge
//   dut_in    out  N_IN    vector driven to DUT; dut_in[N_IN-1] = in1 (MSB) ... dut_in[0] = inN
//   dut_out   in   1       DUT output
//   busy      out  1       high from the cycle after start-accept until done
//   done      out  1       one-cycle pulse, sweep complete; tt_code and match valid from this cycle
//   tt_code   out  CODE_W  tt_code[k] = dut_out sampled with dut_in == k; held until next start-accept
//   match     out  1       (tt_code == captured exp_code); valid with done, held with tt_code
//   unstable  out  CODE_W  per-row stability flags (macro only; constant 0 otherwise)
// BEHAVIOUR
//   Reset: state IDLE; busy=0, done=0, dut_in=0, tt_code=0, match=0, unstable=0, internal counters 0.
//   FSM states and transitions:
//     IDLE   -> HOLD  on start && !busy; capture exp_code; clear tt_code/match/unstable; row=0.
//     HOLD   dut_in=row; settle counter counts 0..SETTLE_CYCLES-1.
//            On count==SETTLE_CYCLES-1 edge: tt_code[row] <= dut_out.
//            If row==CODE_W-1 -> FINISH; else row++, counter=0, stay in HOLD.
//     FINISH one cycle: done=1, busy=0, match computed from complete tt_code; -> IDLE.
//   Timing:
//     - Each row is driven for exactly SETTLE_CYCLES cycles.
//     - Start-accept to done = CODE_W*SETTLE_CYCLES + 1 cycles (33 for the defaults).
//   Boundaries:
//     - start while busy (HOLD/FINISH): ignored, no effect.
//     - start in IDLE in the same cycle as done: not possible (done only in FINISH).
//     - Row counter must not wrap; sweep ends at CODE_W-1.
//     - After the sweep, dut_in returns to 0 in IDLE.
//     - rst asserted mid-sweep: full return to reset values next edge; partial tt_code is discarded; no done pulse.
//     - rst wins over a simultaneous start.
//   Widths: row counter N_IN+1 bits; settle counter $clog2(SETTLE_CYCLES+1) bits; match is full CODE_W equality.
// CONFIGURATION
//   `TT_SWEEP_STABILITY_CHECK_EN defined:
//     - During the last STABLE_CYCLES cycles of each HOLD window, register dut_out each cycle.
//     - If any sample differs from the first sample in that window, set unstable[row] (sticky until next start-accept).
//     - match is additionally forced 0 if unstable != 0.
//   Macro undefined: no stability logic; unstable tied to 0; match = pure code compare.
// STRUCTURE
//   Package tt_sweep_pkg:
//     - state enum {IDLE, HOLD, FINISH}
//     - function code_w(n) = 1<<n
//     - localparam defaults for N_IN/SETTLE_CYCLES
//   Sub-module tt_settle_timer:
//     - inputs clear, enable; output last (count==SETTLE_CYCLES-1); output in_window (count >= SETTLE_CYCLES-STABLE_CYCLES).
//     - Instantiated once.
// TESTING
//   1 DUT out=1 const, exp_code=8'hFF, start -> done after exactly 33 cycles, tt_code=8'hFF, match=1
//   2 DUT = in1&in2&in3, exp_code=8'h80 -> tt_code=8'h80, match=1; rerun with exp_code=8'h81 -> match=0
//   3 DUT = ~(in1|in2|in3) -> tt_code=8'h01; dut_in observed as 0,1,...,7, each held 4 cycles
//   4 start pulsed again at cycle 10 of a sweep -> ignored; single done at cycle 33; busy never drops early
//   5 rst at cycle 15 mid-sweep -> next edge busy=0, tt_code=0, dut_in=0, no done; new start gives a correct full sweep
//   6 (macro) DUT toggles dut_out each cycle only while dut_in==5 -> unstable=8'h20, match=0 even with exp_code equal to tt_code

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared types and defaults for the truth-table sweeper.
//   state_t  : sweep FSM states
//   code_w() : truth-table code width for a given input count (2**n)
//   DEFAULT_*: default parameter values used by the top, the timer and the interface
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHold   = 2'd1,
        StFinish = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_N_IN          = 3;
    localparam int unsigned DEFAULT_SETTLE_CYCLES = 4;
    localparam int unsigned DEFAULT_STABLE_CYCLES = 2;

    function automatic int unsigned code_w(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/result bundle between a test host and truth_table_sweeper.
//   master: host side  (drives start, exp_code; reads busy, done, tt_code, match, unstable)
//   slave : sweeper side
interface truth_table_sweeper_if
    import tt_sweep_pkg::*;
#(
    parameter int unsigned N_IN = DEFAULT_N_IN
);
    localparam int unsigned CODE_W = code_w(N_IN);

    logic              start;
    logic [CODE_W-1:0] exp_code;
    logic              busy;
    logic              done;
    logic [CODE_W-1:0] tt_code;
    logic              match;
    logic [CODE_W-1:0] unstable;

    modport master (
        output start, exp_code,
        input  busy, done, tt_code, match, unstable
    );

    modport slave (
        input  start, exp_code,
        output busy, done, tt_code, match, unstable
    );

endinterface

// File: rtl/tt_settle_timer.sv
// Per-row hold timer for the truth-table sweeper.
// Counts 0..SETTLE_CYCLES-1 while enabled and wraps to 0 after the last count.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : force count to 0 (new sweep)
//   enable    : advance count this cycle
//   last      : count == SETTLE_CYCLES-1 (sampling cycle of the row)
//   in_window : count is inside the final STABLE_CYCLES cycles of the hold window
module tt_settle_timer
    import tt_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last,
    output logic in_window
);
    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign last      = (count_q == CNT_W'(SETTLE_CYCLES - 1));
    assign in_window = (count_q >= CNT_W'(SETTLE_CYCLES - STABLE_CYCLES));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = last ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives every input combination into a combinational circuit,
// holds each for SETTLE_CYCLES cycles, samples the output on the last cycle and assembles
// the truth-table code (tt_code[k] = output with input vector k), then compares it against
// the expected code captured at start.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   ctl      : truth_table_sweeper_if.slave (start/exp_code in; busy/done/tt_code/match/unstable out)
//   dut_in   : vector driven to the circuit under test (MSB = in1)
//   dut_out  : output of the circuit under test
// Build option: define TT_SWEEP_STABILITY_CHECK_EN to flag rows whose output moves during
// the last STABLE_CYCLES cycles of the hold window; flagged rows force match low.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int unsigned N_IN          = DEFAULT_N_IN,
    parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    truth_table_sweeper_if.slave   ctl,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out
);
    localparam int unsigned CODE_W = code_w(N_IN);
    localparam int unsigned ROW_W  = N_IN + 1;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CODE_W-1:0] tt_q, tt_d;
    logic [CODE_W-1:0] exp_q, exp_d;
    logic              match_q, match_d;
    logic [CODE_W-1:0] unst_d;

    logic accept;
    logic hold;
    logic last;
    logic row_last;

    assign accept   = (state_q == StIdle) && ctl.start;
    assign hold     = (state_q == StHold);
    assign row_last = (row_q == ROW_W'(CODE_W - 1));

`ifdef TT_SWEEP_STABILITY_CHECK_EN
    logic              in_window;
    logic [CODE_W-1:0] unst_q;
    logic              first_q, first_d;
    logic              seen_q, seen_d;

    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .enable    (hold),
        .last      (last),
        .in_window (in_window)
    );

    // First in-window sample of a row is the reference; any later in-window sample that
    // differs marks the row. seen is cleared at the end of each row.
    always_comb begin
        unst_d  = unst_q;
        first_d = first_q;
        seen_d  = seen_q;
        if (accept) begin
            unst_d = '0;
            seen_d = 1'b0;
        end else if (hold && in_window) begin
            if (!seen_q) begin
                first_d = dut_out;
                seen_d  = 1'b1;
            end else if (dut_out != first_q) begin
                unst_d[row_q[N_IN-1:0]] = 1'b1;
            end
            if (last) begin
                seen_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            unst_q  <= '0;
            first_q <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            unst_q  <= unst_d;
            first_q <= first_d;
            seen_q  <= seen_d;
        end
    end

    assign ctl.unstable = unst_q;
`else
    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .enable    (hold),
        .last      (last),
        .in_window ()
    );

    assign unst_d       = '0;
    assign ctl.unstable = '0;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        tt_d    = tt_q;
        exp_d   = exp_q;
        match_d = match_q;
        unique case (state_q)
            StIdle: begin
                if (ctl.start) begin
                    state_d = StHold;
                    exp_d   = ctl.exp_code;
                    tt_d    = '0;
                    match_d = 1'b0;
                    row_d   = '0;
                end
            end
            StHold: begin
                if (last) begin
                    tt_d[row_q[N_IN-1:0]] = dut_out;
                    if (row_last) begin
                        // Final row: match is evaluated on the completed code so it is
                        // valid in the same cycle as done.
                        state_d = StFinish;
                        row_d   = '0;
                        match_d = (tt_d == exp_q) && (unst_d == '0);
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            tt_q    <= '0;
            exp_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            tt_q    <= tt_d;
            exp_q   <= exp_d;
            match_q <= match_d;
        end
    end

    // row is forced to 0 outside a sweep, so it doubles as the driven vector.
    assign dut_in    = row_q[N_IN-1:0];
    assign ctl.busy  = hold;
    assign ctl.done  = (state_q == StFinish);
    assign ctl.tt_code = tt_q;
    assign ctl.match   = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with the default geometry (3 inputs, 4-cycle hold).
// Cycle numbering: cycle 1 is the first cycle after the start-accept edge; outputs are
// sampled on the falling edge.
module tb_truth_table_sweeper;
    import tt_sweep_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dut_in;
    logic       dut_out;
    int         mode = 0;
    logic       tog = 1'b0;
    logic       tog_clr = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    truth_table_sweeper_if #(.N_IN(3)) ctl ();

    truth_table_sweeper #(
        .N_IN          (3),
        .SETTLE_CYCLES (4),
        .STABLE_CYCLES (2)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .ctl     (ctl),
        .dut_in  (dut_in),
        .dut_out (dut_out)
    );

    always #5 clk = ~clk;

    // Circuit under test models; dut_in[2] = in1.
    always_comb begin
        dut_out = 1'b0;
        case (mode)
            0: dut_out = 1'b1;
            1: dut_out = &dut_in;
            2: dut_out = ~|dut_in;
            3: dut_out = dut_in[2] ^ tog;
            default: dut_out = 1'b0;
        endcase
    end

    // Toggles only while row 5 is driven.
    always @(posedge clk) begin
        if (tog_clr) tog <= 1'b0;
        else if (dut_in == 3'd5) tog <= ~tog;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue a start, then watch cycles 1..40. Optionally re-pulse start or assert rst in a
    // given cycle. Returns first done cycle, done pulse count, busy/dut_in sequence flags and
    // a snapshot of the cycle following rst.
    task automatic sweep(input logic [7:0] e, input int restart_at, input int rst_at,
                         output int done_cyc, output int n_done,
                         output logic busy_ok, output logic din_ok,
                         output logic [7:0] snap_tt, output logic snap_busy,
                         output logic [2:0] snap_din);
        done_cyc  = -1;
        n_done    = 0;
        busy_ok   = 1'b1;
        din_ok    = 1'b1;
        snap_tt   = 8'hxx;
        snap_busy = 1'bx;
        snap_din  = 3'bxxx;
        @(negedge clk);
        ctl.start    = 1'b1;
        ctl.exp_code = e;
        @(negedge clk);
        for (int c = 1; c <= 40; c++) begin
            if (ctl.done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (rst_at == 0 || c <= rst_at) begin
                if (ctl.busy !== (c <= 32)) busy_ok = 1'b0;
                if (dut_in !== ((c <= 32) ? 3'((c - 1) / 4) : 3'd0)) din_ok = 1'b0;
            end
            if (rst_at > 0 && c == rst_at + 1) begin
                snap_tt   = ctl.tt_code;
                snap_busy = ctl.busy;
                snap_din  = dut_in;
            end
            ctl.start = (c == restart_at);
            rst       = (c == rst_at);
            @(negedge clk);
        end
        ctl.start = 1'b0;
        rst       = 1'b0;
    endtask

    int         dc, nd;
    logic       bok, dok, sb;
    logic [7:0] st;
    logic [2:0] sd;

    initial begin
        ctl.start    = 1'b0;
        ctl.exp_code = 8'h00;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", ctl.busy, 0);
        check("rst_done", ctl.done, 0);
        check("rst_din", dut_in, 0);
        check("rst_tt", ctl.tt_code, 0);
        check("rst_match", ctl.match, 0);
        check("rst_unstable", ctl.unstable, 0);
        rst = 1'b0;

        // 1: constant 1
        mode = 0;
        sweep(8'hFF, 0, 0, dc, nd, bok, dok, st, sb, sd);
        check("t1_done_cycle", dc, 33);
        check("t1_done_count", nd, 1);
        check("t1_busy_seq", bok, 1);
        check("t1_tt", ctl.tt_code, 8'hFF);
        check("t1_match", ctl.match, 1);
        check("t1_din_idle", dut_in, 0);

        // 2: 3-input AND, matching then non-matching expectation
        mode = 1;
        sweep(8'h80, 0, 0, dc, nd, bok, dok, st, sb, sd);
        check("t2_tt", ctl.tt_code, 8'h80);
        check("t2_match", ctl.match, 1);
        sweep(8'h81, 0, 0, dc, nd, bok, dok, st, sb, sd);
        check("t2b_tt", ctl.tt_code, 8'h80);
        check("t2b_match", ctl.match, 0);

        // 3: 3-input NOR, row sequence and hold length
        mode = 2;
        sweep(8'h01, 0, 0, dc, nd, bok, dok, st, sb, sd);
        check("t3_tt", ctl.tt_code, 8'h01);
        check("t3_match", ctl.match, 1);
        check("t3_din_seq", dok, 1);

        // 4: start re-pulsed mid-sweep is ignored
        mode = 1;
        sweep(8'h80, 10, 0, dc, nd, bok, dok, st, sb, sd);
        check("t4_done_cycle", dc, 33);
        check("t4_done_count", nd, 1);
        check("t4_busy_seq", bok, 1);
        check("t4_tt", ctl.tt_code, 8'h80);
        check("t4_match", ctl.match, 1);

        // 5: reset mid-sweep, then a clean sweep
        mode = 2;
        sweep(8'h01, 0, 15, dc, nd, bok, dok, st, sb, sd);
        check("t5_busy_after_rst", sb, 0);
        check("t5_tt_after_rst", st, 0);
        check("t5_din_after_rst", sd, 0);
        check("t5_no_done", nd, 0);
        check("t5_busy_before_rst", bok, 1);
        sweep(8'h01, 0, 0, dc, nd, bok, dok, st, sb, sd);
        check("t5b_done_cycle", dc, 33);
        check("t5b_tt", ctl.tt_code, 8'h01);
        check("t5b_match", ctl.match, 1);

        // rst wins over a simultaneous start
        @(negedge clk);
        ctl.start = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        ctl.start = 1'b0;
        rst       = 1'b0;
        check("rst_vs_start_busy", ctl.busy, 0);
        check("rst_vs_start_tt", ctl.tt_code, 0);

        // 6: output toggles only while row 5 is driven
        mode    = 3;
        tog_clr = 1'b1;
        @(negedge clk);
        tog_clr = 1'b0;
`ifdef TT_SWEEP_STABILITY_CHECK_EN
        sweep(8'hD0, 0, 0, dc, nd, bok, dok, st, sb, sd);
        check("t6_tt", ctl.tt_code, 8'hD0);
        check("t6_unstable", ctl.unstable, 8'h20);
        check("t6_match", ctl.match, 0);
`else
        sweep(8'hD0, 0, 0, dc, nd, bok, dok, st, sb, sd);
        check("t6_tt", ctl.tt_code, 8'hD0);
        check("t6_unstable", ctl.unstable, 8'h00);
        check("t6_match", ctl.match, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
